id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_if.sv | 76 +++++++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle of every signal that crosses the ID/EX pipeline boundary. It carries
//   the decode-side fields, the EX redirect, the registered EX-side fields, the
//   hazard stalls and the bubble counter.
//
//   Modports
//     master : drives the decode fields and flush_e, and observes the EX
//              fields, the stalls and bubble_cnt (decoder / hazard unit side).
//     slave  : the ID/EX register itself (id_ex_stage).
// -----------------------------------------------------------------------------
interface id_ex_stage_if;

    // Decode-side fields
    logic        valid_d;
    logic        regwrite_d;
    logic        memwrite_d;
    logic        alu_src_d;
    logic        branch_d;
    logic        jump_d;
    logic [1:0]  result_src_d;   // 00 ALU, 01 load, 10 PC+4
    logic [2:0]  alu_control_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] imm_ext_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;

    // Redirect from EX (taken branch or jump)
    logic        flush_e;

    // Registered EX-side fields
    logic        valid_e;
    logic        regwrite_e;
    logic        memwrite_e;
    logic        alu_src_e;
    logic        branch_e;
    logic        jump_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_ext_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;

    // Hazard outputs
    logic        stall_f;
    logic        stall_d;
    logic [15:0] bubble_cnt;

    modport master (
        output valid_d, regwrite_d, memwrite_d, alu_src_d, branch_d, jump_d,
               result_src_d, alu_control_d, rd1_d, rd2_d, imm_ext_d, pc_d,
               pc_plus4_d, rs1_d, rs2_d, rd_d, flush_e,
        input  valid_e, regwrite_e, memwrite_e, alu_src_e, branch_e, jump_e,
               result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e,
               pc_plus4_e, rs1_e, rs2_e, rd_e, stall_f, stall_d, bubble_cnt
    );

    modport slave (
        input  valid_d, regwrite_d, memwrite_d, alu_src_d, branch_d, jump_d,
               result_src_d, alu_control_d, rd1_d, rd2_d, imm_ext_d, pc_d,
               pc_plus4_d, rs1_d, rs2_d, rd_d, flush_e,
        output valid_e, regwrite_e, memwrite_e, alu_src_e, branch_e, jump_e,
               result_src_e, alu_control_e, rd1_e, rd2_e, imm_ext_e, pc_e,
               pc_plus4_e, rs1_e, rs2_e, rd_e, stall_f, stall_d, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection and bubble insertion.
//
//   Every cycle the decode fields are captured into the EX register unless a
//   bubble is inserted (flush, load-use hazard, or no valid instruction in D);
//   a bubble loads an all-zero EX word. The EX register itself never stalls.
//   On a load-use hazard the front end is held for one cycle via stall_f /
//   stall_d; a redirect (flush_e) overrides the stall so the new PC proceeds.
//   bubble_cnt counts bubbles caused by flush or load-use, saturating at FFFF.
//
//   Ports
//     clk     : rising-edge clock
//     rst_n   : synchronous active-low reset (clears EX state and bubble_cnt)
//     pipe_if : id_ex_stage_if.slave -- decode inputs, flush_e, EX outputs,
//               stall_f / stall_d (combinational), bubble_cnt (registered)
// -----------------------------------------------------------------------------
module id_ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave pipe_if
);

    localparam logic [1:0]  RES_LOAD = 2'b01;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // One EX-stage word; an all-zero value is a bubble.
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_word_t;

    ex_word_t    ex_q, ex_d;
    ex_word_t    d_word;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        load_use;
    logic        bubble;
    logic        counted_bubble;

    // Pack the decode fields into one word so capture is a single assignment.
    assign d_word = '{
        valid:       pipe_if.valid_d,
        regwrite:    pipe_if.regwrite_d,
        memwrite:    pipe_if.memwrite_d,
        alu_src:     pipe_if.alu_src_d,
        branch:      pipe_if.branch_d,
        jump:        pipe_if.jump_d,
        result_src:  pipe_if.result_src_d,
        alu_control: pipe_if.alu_control_d,
        rd1:         pipe_if.rd1_d,
        rd2:         pipe_if.rd2_d,
        imm_ext:     pipe_if.imm_ext_d,
        pc:          pipe_if.pc_d,
        pc_plus4:    pipe_if.pc_plus4_d,
        rs1:         pipe_if.rs1_d,
        rs2:         pipe_if.rs2_d,
        rd:          pipe_if.rd_d
    };

    // Load-use: the load in EX writes a register the D instruction reads.
    // rs2 is compared for every format, so I-type instructions may stall
    // spuriously; x0 is never a real dependency.
    assign load_use = ex_q.valid
                   && (ex_q.result_src == RES_LOAD)
                   && (ex_q.rd != 5'd0)
                   && ((pipe_if.rs1_d == ex_q.rd) || (pipe_if.rs2_d == ex_q.rd));

    // A redirect wins over the hazard: the D instruction is being killed anyway.
    assign pipe_if.stall_f = load_use && !pipe_if.flush_e;
    assign pipe_if.stall_d = load_use && !pipe_if.flush_e;

    assign counted_bubble = pipe_if.flush_e || load_use;
    assign bubble         = counted_bubble || !pipe_if.valid_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        ex_d         = d_word;
        bubble_cnt_d = bubble_cnt_q;

        if (bubble) begin
            ex_d = '0;
        end

        if (counted_bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pipe_if.valid_e       = ex_q.valid;
    assign pipe_if.regwrite_e    = ex_q.regwrite;
    assign pipe_if.memwrite_e    = ex_q.memwrite;
    assign pipe_if.alu_src_e     = ex_q.alu_src;
    assign pipe_if.branch_e      = ex_q.branch;
    assign pipe_if.jump_e        = ex_q.jump;
    assign pipe_if.result_src_e  = ex_q.result_src;
    assign pipe_if.alu_control_e = ex_q.alu_control;
    assign pipe_if.rd1_e         = ex_q.rd1;
    assign pipe_if.rd2_e         = ex_q.rd2;
    assign pipe_if.imm_ext_e     = ex_q.imm_ext;
    assign pipe_if.pc_e          = ex_q.pc;
    assign pipe_if.pc_plus4_e    = ex_q.pc_plus4;
    assign pipe_if.rs1_e         = ex_q.rs1;
    assign pipe_if.rs2_e         = ex_q.rs2;
    assign pipe_if.rd_e          = ex_q.rd;
    assign pipe_if.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. The driver applies one decode vector per
//   cycle on the falling edge and pushes the hand-derived expectation (stall
//   level for that cycle, EX word and bubble_cnt after the next rising edge)
//   into a scoreboard queue. An independent monitor pops each entry and
//   compares: stalls shortly after the falling edge, EX state after the rising
//   edge.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } word_t;

    typedef struct {
        string       name;
        bit          chk_stall;
        bit          exp_stall;
        word_t       exp_e;
        logic [15:0] exp_cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    id_ex_stage_if pipe_if ();

    id_ex_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pipe_if (pipe_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic word_t sample_e();
        word_t w;
        w = '{
            valid:       pipe_if.valid_e,
            regwrite:    pipe_if.regwrite_e,
            memwrite:    pipe_if.memwrite_e,
            alu_src:     pipe_if.alu_src_e,
            branch:      pipe_if.branch_e,
            jump:        pipe_if.jump_e,
            result_src:  pipe_if.result_src_e,
            alu_control: pipe_if.alu_control_e,
            rd1:         pipe_if.rd1_e,
            rd2:         pipe_if.rd2_e,
            imm_ext:     pipe_if.imm_ext_e,
            pc:          pipe_if.pc_e,
            pc_plus4:    pipe_if.pc_plus4_e,
            rs1:         pipe_if.rs1_e,
            rs2:         pipe_if.rs2_e,
            rd:          pipe_if.rd_e
        };
        return w;
    endfunction

    // Apply one vector on the falling edge.
    task automatic drive(input word_t v, input logic fl, input logic rst);
        @(negedge clk);
        rst_n                 = rst;
        pipe_if.flush_e       = fl;
        pipe_if.valid_d       = v.valid;
        pipe_if.regwrite_d    = v.regwrite;
        pipe_if.memwrite_d    = v.memwrite;
        pipe_if.alu_src_d     = v.alu_src;
        pipe_if.branch_d      = v.branch;
        pipe_if.jump_d        = v.jump;
        pipe_if.result_src_d  = v.result_src;
        pipe_if.alu_control_d = v.alu_control;
        pipe_if.rd1_d         = v.rd1;
        pipe_if.rd2_d         = v.rd2;
        pipe_if.imm_ext_d     = v.imm_ext;
        pipe_if.pc_d          = v.pc;
        pipe_if.pc_plus4_d    = v.pc_plus4;
        pipe_if.rs1_d         = v.rs1;
        pipe_if.rs2_d         = v.rs2;
        pipe_if.rd_d          = v.rd;
    endtask

    task automatic expect_cycle(input string name, input bit cs, input bit es,
                                input word_t ee, input logic [15:0] ec);
        exp_t e;
        e.name      = name;
        e.chk_stall = cs;
        e.exp_stall = es;
        e.exp_e     = ee;
        e.exp_cnt   = ec;
        sb.push_back(e);
    endtask

    function automatic word_t rand_word();
        word_t w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        w.valid = 1'b1;
        return w;
    endfunction

    // Monitor: one scoreboard entry per driven cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk_stall) begin
                    check({e.name, " stall_f"}, 256'(pipe_if.stall_f), 256'(e.exp_stall));
                    check({e.name, " stall_d"}, 256'(pipe_if.stall_d), 256'(e.exp_stall));
                end
                @(posedge clk);
                #1;
                check({e.name, " ex_word"}, 256'(sample_e()), 256'(e.exp_e));
                check({e.name, " bubble_cnt"}, 256'(pipe_if.bubble_cnt), 256'(e.exp_cnt));
            end
        end
    end

    initial begin : driver
        word_t v_add, v_lw, v_dep, v_ld0, v_x0, v_lw12, v_st, v_inv, v_lw15, v_dep15, v_fl;
        int    wait_cyc;

        rst_n = 1'b0;
        pipe_if.flush_e = 1'b0;
        {pipe_if.valid_d, pipe_if.regwrite_d, pipe_if.memwrite_d, pipe_if.alu_src_d,
         pipe_if.branch_d, pipe_if.jump_d, pipe_if.result_src_d, pipe_if.alu_control_d,
         pipe_if.rd1_d, pipe_if.rd2_d, pipe_if.imm_ext_d, pipe_if.pc_d, pipe_if.pc_plus4_d,
         pipe_if.rs1_d, pipe_if.rs2_d, pipe_if.rd_d} = '0;

        // Reset with valid random decode data: EX must stay zero.
        drive(rand_word(), 1'b0, 1'b0);
        expect_cycle("reset1", 0, 0, '0, 16'd0);
        drive(rand_word(), 1'b0, 1'b0);
        expect_cycle("reset2", 1, 0, '0, 16'd0);

        // Pass-through add x5 <- x1 + x2.
        v_add = '0;
        v_add.valid = 1; v_add.regwrite = 1; v_add.alu_control = 3'b010;
        v_add.rd1 = 32'h10; v_add.rd2 = 32'h22; v_add.imm_ext = 32'hABCD_0123;
        v_add.pc = 32'h100; v_add.pc_plus4 = 32'h104;
        v_add.rs1 = 5'd1; v_add.rs2 = 5'd2; v_add.rd = 5'd5;
        drive(v_add, 1'b0, 1'b1);
        expect_cycle("add", 1, 0, v_add, 16'd0);

        // lw x7 reads x5: EX holds a non-load with rd=5, so no stall.
        v_lw = '0;
        v_lw.valid = 1; v_lw.regwrite = 1; v_lw.alu_src = 1; v_lw.result_src = 2'b01;
        v_lw.rd1 = 32'h2000; v_lw.imm_ext = 32'h8; v_lw.pc = 32'h104; v_lw.pc_plus4 = 32'h108;
        v_lw.rs1 = 5'd5; v_lw.rs2 = 5'd3; v_lw.rd = 5'd7;
        drive(v_lw, 1'b0, 1'b1);
        expect_cycle("lw_x7", 1, 0, v_lw, 16'd0);

        // Dependent add reads x7: load-use stall and bubble.
        v_dep = '0;
        v_dep.valid = 1; v_dep.regwrite = 1; v_dep.alu_control = 3'b010; v_dep.branch = 1;
        v_dep.rd1 = 32'h55; v_dep.rd2 = 32'h66; v_dep.pc = 32'h108; v_dep.pc_plus4 = 32'h10C;
        v_dep.rs1 = 5'd7; v_dep.rs2 = 5'd4; v_dep.rd = 5'd8;
        drive(v_dep, 1'b0, 1'b1);
        expect_cycle("loaduse_stall", 1, 1, '0, 16'd1);
        // Held instruction re-presented: hazard gone after one bubble.
        drive(v_dep, 1'b0, 1'b1);
        expect_cycle("loaduse_release", 1, 0, v_dep, 16'd1);

        // Load to x0 followed by reads of x0: no stall.
        v_ld0 = '0;
        v_ld0.valid = 1; v_ld0.regwrite = 1; v_ld0.result_src = 2'b01; v_ld0.alu_src = 1;
        v_ld0.pc = 32'h10C; v_ld0.pc_plus4 = 32'h110; v_ld0.rs1 = 5'd3; v_ld0.rs2 = 5'd4; v_ld0.rd = 5'd0;
        drive(v_ld0, 1'b0, 1'b1);
        expect_cycle("ld_x0", 1, 0, v_ld0, 16'd1);
        v_x0 = '0;
        v_x0.valid = 1; v_x0.regwrite = 1; v_x0.jump = 1; v_x0.result_src = 2'b10;
        v_x0.alu_control = 3'b111; v_x0.rd2 = 32'hFFFF_FFFF; v_x0.pc = 32'h110; v_x0.pc_plus4 = 32'h114;
        v_x0.rs1 = 5'd0; v_x0.rs2 = 5'd0; v_x0.rd = 5'd9;
        drive(v_x0, 1'b0, 1'b1);
        expect_cycle("x0_exempt", 1, 0, v_x0, 16'd1);

        // Load x12, then a store reading x12 (via rs2) together with a flush.
        v_lw12 = v_lw;
        v_lw12.rs1 = 5'd9; v_lw12.rd = 5'd12;
        drive(v_lw12, 1'b0, 1'b1);
        expect_cycle("lw_x12", 1, 0, v_lw12, 16'd1);
        v_st = '0;
        v_st.valid = 1; v_st.memwrite = 1; v_st.alu_src = 1; v_st.rd2 = 32'h1234;
        v_st.rs1 = 5'd2; v_st.rs2 = 5'd12; v_st.rd = 5'd0;
        drive(v_st, 1'b1, 1'b1);
        expect_cycle("flush_over_hazard", 1, 0, '0, 16'd2);

        // Invalid D slot: bubble but not counted.
        v_inv = rand_word();
        v_inv.valid = 0;
        drive(v_inv, 1'b0, 1'b1);
        expect_cycle("invalid_d", 1, 0, '0, 16'd2);

        // Reset in the middle of a load-use hazard.
        v_lw15 = v_lw;
        v_lw15.rd = 5'd15;
        drive(v_lw15, 1'b0, 1'b1);
        expect_cycle("lw_x15", 1, 0, v_lw15, 16'd2);
        v_dep15 = v_dep;
        v_dep15.rs1 = 5'd1; v_dep15.rs2 = 5'd15;
        drive(v_dep15, 1'b0, 1'b0);
        expect_cycle("reset_mid_stall", 0, 0, '0, 16'd0);
        drive(v_dep15, 1'b0, 1'b1);
        expect_cycle("after_reset", 1, 0, v_dep15, 16'd0);

        // Saturation: 65533 unchecked flushes, then FFFE and three more.
        v_fl = v_add;
        for (int i = 0; i < 65533; i++) begin
            drive(v_fl, 1'b1, 1'b1);
        end
        drive(v_fl, 1'b1, 1'b1);
        expect_cycle("cnt_fffe", 1, 0, '0, 16'hFFFE);
        drive(v_fl, 1'b1, 1'b1);
        expect_cycle("cnt_sat1", 1, 0, '0, 16'hFFFF);
        drive(v_fl, 1'b1, 1'b1);
        expect_cycle("cnt_sat2", 1, 0, '0, 16'hFFFF);
        drive(v_fl, 1'b1, 1'b1);
        expect_cycle("cnt_sat3", 1, 0, '0, 16'hFFFF);
        drive(v_add, 1'b0, 1'b1);
        expect_cycle("cnt_hold", 1, 0, v_add, 16'hFFFF);

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 256'(sb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
